// File: rtl/burst_splitter.sv
// burst_splitter: pops (address, length) transfer requests and splits each
// one into bursts. A burst never exceeds MaxBurstBeats and never crosses a
// 4 KiB page. Every burst command is pushed to the address-channel FIFO and,
// in the same cycle, its encoded length is pushed to the last-flag FIFO.
// Optional feature: define BURST_SPLITTER_STATS_EN to add the req_count and
// burst_count statistics outputs.
module burst_splitter #(
  parameter int AddrWidth      = 64,
  parameter int LenWidth       = 32,
  parameter int BurstLenWidth  = 8,
  parameter int DataWidthBytes = 64,
  parameter int MaxBurstBeats  = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AddrWidth-1:0]     req_addr_dout,
  input  logic [LenWidth-1:0]      req_len_dout,
  input  logic                     req_empty_n,
  output logic                     req_read,
  output logic [AddrWidth-1:0]     burst_addr_din,
  output logic [BurstLenWidth-1:0] burst_len_din,
  input  logic                     burst_full_n,
  output logic                     burst_write,
  output logic [BurstLenWidth-1:0] last_len_din,
  input  logic                     last_full_n,
  output logic                     last_write,
  output logic                     busy
`ifdef BURST_SPLITTER_STATS_EN
  ,
  output logic [31:0]              req_count,
  output logic [31:0]              burst_count
`endif
);

  localparam int OffBits = $clog2(DataWidthBytes);
  // Clears the sub-beat byte offset of a request address.
  localparam logic [AddrWidth-1:0] AlignMask = ~(AddrWidth'(DataWidthBytes - 1));
  localparam logic [LenWidth-1:0]  PageBytes = LenWidth'(13'd4096);
  localparam logic [LenWidth-1:0]  MaxBeats  = LenWidth'(MaxBurstBeats);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [AddrWidth-1:0]   addr_r;
  logic [LenWidth-1:0]    remaining_r;

  logic [LenWidth-1:0]    to_boundary_s;
  logic [LenWidth-1:0]    capped_s;
  logic [LenWidth-1:0]    beats_s;
  logic [BurstLenWidth-1:0] burst_len_s;
  logic                   pop_s;
  logic                   push_s;

  // Size of the current burst: remaining beats capped by the burst limit
  // and by the distance to the next 4 KiB page.
  always_comb begin
    to_boundary_s = (PageBytes - LenWidth'(addr_r[11:0])) >> OffBits;
    capped_s      = (remaining_r < MaxBeats) ? remaining_r : MaxBeats;
    beats_s       = (capped_s < to_boundary_s) ? capped_s : to_boundary_s;
    burst_len_s   = BurstLenWidth'(beats_s - LenWidth'(1'b1));
  end

  // Next-state and handshake decisions; a push only happens when both
  // downstream FIFOs can accept so the two streams stay in lockstep.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    push_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_empty_n) begin
          pop_s = 1'b1;
          if (req_len_dout != {LenWidth{1'b0}}) begin
            state_s = SPLIT;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SPLIT: begin
        if (burst_full_n && last_full_n) begin
          push_s = 1'b1;
          if (remaining_r == beats_s) begin
            state_s = IDLE;
          end else begin
            state_s = SPLIT;
          end
        end else begin
          state_s = SPLIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output drive; reset suppresses any same-cycle pop or push.
  always_comb begin
    req_read       = pop_s & ~rst;
    burst_write    = push_s & ~rst;
    last_write     = push_s & ~rst;
    burst_addr_din = addr_r;
    burst_len_din  = burst_len_s;
    last_len_din   = burst_len_s;
    busy           = (state_r == SPLIT);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Address and remaining-beat registers: load on pop, advance on push.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r      <= {AddrWidth{1'b0}};
      remaining_r <= {LenWidth{1'b0}};
    end else if (pop_s) begin
      addr_r      <= req_addr_dout & AlignMask;
      remaining_r <= req_len_dout;
    end else if (push_s) begin
      addr_r      <= addr_r + (AddrWidth'(beats_s) << OffBits);
      remaining_r <= remaining_r - beats_s;
    end else begin
      addr_r      <= addr_r;
      remaining_r <= remaining_r;
    end
  end

`ifdef BURST_SPLITTER_STATS_EN
  // Free-running request and burst counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_count   <= 32'd0;
      burst_count <= 32'd0;
    end else begin
      req_count   <= req_count + (pop_s ? 32'd1 : 32'd0);
      burst_count <= burst_count + (push_s ? 32'd1 : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_burst_splitter.sv
// Scoreboard bench for burst_splitter (DataWidthBytes=64, MaxBurstBeats=16).
// Requests come from a queue; each popped request is expanded into its
// expected bursts by a plain arithmetic model, and a monitor compares every
// cycle away from the clock edge.
module tb_burst_splitter;

  typedef struct packed { logic [63:0] a; logic [31:0] n; } req_t;
  typedef struct packed { logic [63:0] a; logic [7:0]  l; } burst_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] req_addr_dout = 64'd0;
  logic [31:0] req_len_dout = 32'd0;
  logic        req_empty_n = 1'b0;
  logic        req_read;
  logic [63:0] burst_addr_din;
  logic [7:0]  burst_len_din;
  logic        burst_full_n = 1'b1;
  logic        burst_write;
  logic [7:0]  last_len_din;
  logic        last_full_n = 1'b1;
  logic        last_write;
  logic        busy;
`ifdef BURST_SPLITTER_STATS_EN
  logic [31:0] req_count;
  logic [31:0] burst_count;
  int unsigned req_m = 0;
  int unsigned burst_m = 0;
`endif

  int     checks = 0;
  int     errors = 0;
  req_t   req_q[$];
  burst_t exp_q[$];
  logic   rand_bp = 1'b0;
  logic   dir_bfull_n = 1'b1;
  logic   dir_lfull_n = 1'b1;
  logic   exp_busy;
  logic   exp_wr;

  burst_splitter #(
    .AddrWidth(64), .LenWidth(32), .BurstLenWidth(8),
    .DataWidthBytes(64), .MaxBurstBeats(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_addr_dout(req_addr_dout), .req_len_dout(req_len_dout),
    .req_empty_n(req_empty_n), .req_read(req_read),
    .burst_addr_din(burst_addr_din), .burst_len_din(burst_len_din),
    .burst_full_n(burst_full_n), .burst_write(burst_write),
    .last_len_din(last_len_din), .last_full_n(last_full_n),
    .last_write(last_write), .busy(busy)
`ifdef BURST_SPLITTER_STATS_EN
    , .req_count(req_count), .burst_count(burst_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: split a request into bursts by the page/limit rules.
  task automatic expand(input req_t r);
    logic [63:0] ad;
    longint unsigned rem, tob, b;
    ad  = r.a & ~64'h3F;
    rem = longint'(r.n);
    while (rem != 0) begin
      tob = (4096 - longint'(ad[11:0])) / 64;
      b = rem;
      if (b > 16) b = 16;
      if (b > tob) b = tob;
      exp_q.push_back('{ad, 8'(b - 1)});
      ad  = ad + 64'(b * 64);
      rem = rem - b;
    end
  endtask

  // Request source and backpressure driver.
  always @(negedge clk) begin
    if (req_q.size() > 0) begin
      req_empty_n   = 1'b1;
      req_addr_dout = req_q[0].a;
      req_len_dout  = req_q[0].n;
    end else begin
      req_empty_n   = 1'b0;
      req_addr_dout = {$urandom, $urandom};
      req_len_dout  = $urandom;
    end
    if (rand_bp) begin
      burst_full_n = ($urandom_range(0, 3) != 0);
      last_full_n  = ($urandom_range(0, 3) != 0);
    end else begin
      burst_full_n = dir_bfull_n;
      last_full_n  = dir_lfull_n;
    end
  end

  // Monitor: compares DUT outputs against the scoreboard each cycle.
  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      exp_q.delete();
`ifdef BURST_SPLITTER_STATS_EN
      req_m = 0;
      burst_m = 0;
`endif
    end else begin
      exp_busy = (exp_q.size() != 0);
      exp_wr   = exp_busy && burst_full_n && last_full_n;
      check("busy", 64'(busy), 64'(exp_busy));
      check("req_read", 64'(req_read), 64'(!exp_busy && req_empty_n));
      check("burst_write", 64'(burst_write), 64'(exp_wr));
      check("last_write", 64'(last_write), 64'(exp_wr));
      if (exp_busy) begin
        check("burst_addr", burst_addr_din, exp_q[0].a);
        check("burst_len", 64'(burst_len_din), 64'(exp_q[0].l));
        check("last_len", 64'(last_len_din), 64'(exp_q[0].l));
      end
`ifdef BURST_SPLITTER_STATS_EN
      check("req_count", 64'(req_count), 64'(req_m));
      check("burst_count", 64'(burst_count), 64'(burst_m));
      if (exp_wr) burst_m++;
      if (!exp_busy && req_empty_n) req_m++;
`endif
      if (burst_write && exp_q.size() > 0) exp_q.pop_front();
      if (!exp_busy && req_empty_n && req_q.size() > 0) begin
        expand(req_q[0]);
        req_q.pop_front();
      end
    end
  end

  task automatic send(input logic [63:0] a, input logic [31:0] n);
    @(negedge clk);
    req_q.push_back('{a, n});
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((req_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: timeout after %0d cycles, %0d bursts pending", n, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send(64'h0, 32'd10);         wait_idle(200);
    send(64'h0, 32'd40);         wait_idle(200);
    send(64'hFC0, 32'd4);        wait_idle(200);
    // Backpressure on each FIFO in turn.
    @(negedge clk);
    dir_lfull_n = 1'b0;
    req_q.push_back('{64'h0, 32'd20});
    repeat (4) @(negedge clk);
    dir_lfull_n = 1'b1;
    dir_bfull_n = 1'b0;
    repeat (2) @(negedge clk);
    dir_bfull_n = 1'b1;
    wait_idle(200);
    // Zero-length request followed by a single-beat one.
    send(64'h0, 32'd0);
    send(64'h40, 32'd1);         wait_idle(200);
    // Address wrap and unaligned start address.
    send(64'hFFFF_FFFF_FFFF_FF80, 32'd5); wait_idle(200);
    send(64'h1234_5FE7, 32'd9);  wait_idle(200);
    // Reset in the middle of a split.
    send(64'h0, 32'd40);
    n = 0;
    while (exp_q.size() != 2 && n < 50) begin
      @(negedge clk);
      #4;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL reset_setup: first burst not seen, %0d pending", exp_q.size());
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(64'h80, 32'd3);         wait_idle(200);
    // Randomized requests under random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send({$urandom, $urandom}, 32'($urandom_range(0, 100)));
    end
    wait_idle(8000);
    rand_bp = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_splitter.md
# burst_splitter

Sequencer ahead of the memory-mapped burst datapath: pops (address, length) transfer requests from a FIFO, splits each into bursts capped by a maximum burst length and the 4 KiB boundary, and emits one burst command per split. Each burst command goes to the address channel. In the same cycle, its encoded length goes to the burst-length FIFO consumed by the last-flag generator, so the two streams stay in lockstep.

## Interface
- AddrWidth, 64, byte address width
- LenWidth, 32, request length width (in beats)
- BurstLenWidth, 8, encoded burst length width (beats-1)
- DataWidthBytes, 64, bytes per beat; power of 2, ≤4096
- MaxBurstBeats, 256, max beats per burst; power of 2, ≤2^BurstLenWidth
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_addr_dout  in  AddrWidth  request start byte address
- req_len_dout  in  LenWidth  request length in beats
- req_empty_n  in  1  request FIFO non-empty
- req_read  out  1  request FIFO pop
- burst_addr_din  out  AddrWidth  burst start byte address
- burst_len_din  out  BurstLenWidth  burst beats-1
- burst_full_n  in  1  burst command FIFO not full
- burst_write  out  1  burst command push
- last_len_din  out  BurstLenWidth  burst beats-1, to last-flag generator
- last_full_n  in  1  burst-length FIFO not full
- last_write  out  1  burst-length push
- busy  out  1  high in SPLIT

## Operation
- State: IDLE, SPLIT. Registers: addr (AddrWidth), remaining (LenWidth).
- IDLE: if req_empty_n, then req_read=1; addr ← req_addr_dout with low log2(DataWidthBytes) bits cleared; remaining ← req_len_dout. If req_len_dout==0, stay in IDLE (request discarded). Otherwise go to SPLIT.
- SPLIT, combinational: to_boundary = (4096 − addr[11:0]) / DataWidthBytes; beats = min(remaining, MaxBurstBeats, to_boundary), computed at LenWidth width.
- burst_addr_din = addr; burst_len_din = last_len_din = beats−1, truncated to BurstLenWidth.
- SPLIT: push only when burst_full_n && last_full_n. In that case burst_write = last_write = 1, addr += beats·DataWidthBytes (wraps modulo 2^AddrWidth), and remaining −= beats. If remaining==beats, go to IDLE.
- Either FIFO full: no push on either output, state holds, and outputs are stable. The two writes are never split.
- req_read is never asserted in SPLIT.

## Timing
- Reset: state IDLE, addr=0, remaining=0, busy=0. req_read, burst_write and last_write are 0.
- All handshake outputs are combinational from state and inputs. Pushes and pops take effect at the clk edge.
- Latency: request popped at cycle t; first burst pushed at t+1 at the earliest.
- Throughput: one burst per cycle while not back-pressured. One IDLE bubble cycle between requests.
- Reset mid-SPLIT: the remainder of the current request is dropped, with no further pushes. Reset wins over a same-cycle pop or push.

## Configuration
- BURST_SPLITTER_STATS_EN defined:
  - Adds outputs req_count[31:0] and burst_count[31:0].
  - req_count increments on each req_read, including zero-length requests.
  - burst_count increments on each burst_write.
  - Both reset to 0 and wrap at 2^32.
- Not defined: ports and counters are absent. Behaviour is otherwise identical.

## Test plan
Configuration for all scenarios: DataWidthBytes=64, MaxBurstBeats=16, BurstLenWidth=8.
- addr 0x0, len 10 → single push (0x0, 9); last_len 9; back to IDLE.
- addr 0x0, len 40 → pushes (0x0,15), (0x400,15), (0x800,7) on consecutive cycles.
- addr 0xFC0, len 4 → pushes (0xFC0,0), (0x1000,2). The 4 KiB boundary is never crossed.
- addr 0x0, len 20 with last_full_n=0 for 3 cycles, then with burst_full_n=0 for 2 cycles → no pushes while either FIFO is full, outputs stable. Then (0x0,15), (0x400,3).
- len 0 request, then addr 0x40, len 1 → first request popped with no push. Second request gives (0x40,0). Under STATS_EN: req_count=2, burst_count=1.
- rst asserted after the first burst of a len-40 request → no further pushes, busy=0, and the next request starts cleanly.
